// File: rtl/tag_stream_packer_wide_if.sv
// Bus bundle for the wide tag-stream packer: narrow single-tag input stream
// on the s_axis_* side, WORD_WIDTH-lane packed output word on the m_axis_* side.
// The master modport is the packer's view; the slave modport is the view of
// the surrounding tag source / wide consumer pair.
interface tag_stream_packer_wide_if #(
  parameter int WORD_WIDTH = 4
);
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tagtime;
  logic [4:0]  s_axis_channel;
  logic        s_axis_rising_edge;

  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [63:0]           m_axis_tagtime     [WORD_WIDTH-1:0];
  logic [4:0]            m_axis_channel     [WORD_WIDTH-1:0];
  logic                  m_axis_rising_edge [WORD_WIDTH-1:0];
  logic [WORD_WIDTH-1:0] m_axis_tkeep;

  modport master (
    input  s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_rising_edge,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tagtime, m_axis_channel, m_axis_rising_edge, m_axis_tkeep,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_rising_edge,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tagtime, m_axis_channel, m_axis_rising_edge, m_axis_tkeep,
    output m_axis_tready
  );
endinterface

// File: rtl/tag_stream_packer_wide.sv
// Packs a stream of single tags into WORD_WIDTH-lane words with a contiguous
// tkeep mask. Partial words are flushed after FLUSH_CYCLES idle clocks
// (0 disables flushing). Optional word/tag statistics counters are built only
// when the macro TAG_PACKER_STATS_EN is defined; otherwise they read 0.
// The interface instance must be parameterised with the same WORD_WIDTH.
module tag_stream_packer_wide #(
  parameter int WORD_WIDTH   = 4,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  tag_stream_packer_wide_if.master bus,
  output logic [31:0]              stat_words,
  output logic [31:0]              stat_tags
);
  localparam int FILL_W  = $clog2(WORD_WIDTH + 1);
  localparam int TIMER_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FILL_W-1:0]  FULL_FILL = FILL_W'(WORD_WIDTH);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(FLUSH_CYCLES);

  logic [FILL_W-1:0]  fill;
  logic [TIMER_W-1:0] timer;
  logic [63:0]        acc_time  [WORD_WIDTH-1:0];
  logic [4:0]         acc_chan  [WORD_WIDTH-1:0];
  logic               acc_edge  [WORD_WIDTH-1:0];

  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_keep;
  logic [63:0]           out_time [WORD_WIDTH-1:0];
  logic [4:0]            out_chan [WORD_WIDTH-1:0];
  logic                  out_edge [WORD_WIDTH-1:0];

  logic out_free, full, in_ready, accept, flush, transfer;

  // Handshake decisions: when a tag is taken and when the accumulator moves out
  always_comb begin
    out_free = !out_valid || bus.m_axis_tready;
    full     = (fill == FULL_FILL);
    in_ready = !full || out_free;
    accept   = bus.s_axis_tvalid && in_ready;
    flush    = (FLUSH_CYCLES != 0) && (fill != '0) && !full && (timer == TIMER_MAX);
    transfer = out_free && (full || flush);
  end

  assign bus.s_axis_tready = in_ready;
  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tkeep  = out_keep;

  for (genvar g = 0; g < WORD_WIDTH; g++) begin : g_lane_out
    assign bus.m_axis_tagtime[g]     = out_time[g];
    assign bus.m_axis_channel[g]     = out_chan[g];
    assign bus.m_axis_rising_edge[g] = out_edge[g];
  end

  // Output word register: load on transfer with unused lanes zeroed, hold until handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_keep  <= '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
        out_time[i] <= '0;
        out_chan[i] <= '0;
        out_edge[i] <= 1'b0;
      end
    end else if (transfer) begin
      out_valid <= 1'b1;
      for (int i = 0; i < WORD_WIDTH; i++) begin
        if (i < int'(fill)) begin
          out_keep[i] <= 1'b1;
          out_time[i] <= acc_time[i];
          out_chan[i] <= acc_chan[i];
          out_edge[i] <= acc_edge[i];
        end else begin
          out_keep[i] <= 1'b0;
          out_time[i] <= '0;
          out_chan[i] <= '0;
          out_edge[i] <= 1'b0;
        end
      end
    end else if (out_valid && bus.m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator: write accepted tag to the next free lane, or lane 0 when the word leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
        acc_time[i] <= '0;
        acc_chan[i] <= '0;
        acc_edge[i] <= 1'b0;
      end
    end else begin
      if (transfer) begin
        fill <= accept ? FILL_W'(1) : '0;
      end else if (accept) begin
        fill <= fill + FILL_W'(1);
      end
      if (accept) begin
        for (int i = 0; i < WORD_WIDTH; i++) begin
          if (transfer ? (i == 0) : (i == int'(fill))) begin
            acc_time[i] <= bus.s_axis_tagtime;
            acc_chan[i] <= bus.s_axis_channel;
            acc_edge[i] <= bus.s_axis_rising_edge;
          end
        end
      end
    end
  end

  // Idle timer: restarts on any accepted tag or empty accumulator, saturates at FLUSH_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (accept || transfer || (fill == '0)) begin
      timer <= '0;
    end else if (!full && (timer != TIMER_MAX)) begin
      timer <= timer + TIMER_W'(1);
    end
  end

`ifdef TAG_PACKER_STATS_EN
  logic [31:0]       words_q, tags_q;
  logic [FILL_W-1:0] keep_count;
  logic [32:0]       tag_sum;

  // Number of valid lanes in the word currently on the output
  always_comb begin
    keep_count = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      keep_count = keep_count + FILL_W'(out_keep[i]);
    end
    tag_sum = {1'b0, tags_q} + 33'(keep_count);
  end

  // Saturating word and tag counters, advanced on each output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      tags_q  <= '0;
    end else if (out_valid && bus.m_axis_tready) begin
      if (words_q != 32'hFFFF_FFFF) begin
        words_q <= words_q + 32'd1;
      end
      tags_q <= tag_sum[32] ? 32'hFFFF_FFFF : tag_sum[31:0];
    end
  end

  assign stat_words = words_q;
  assign stat_tags  = tags_q;
`else
  assign stat_words = '0;
  assign stat_tags  = '0;
`endif
endmodule

// File: tb/tb_tag_stream_packer_wide.sv
// Directed testbench for tag_stream_packer_wide (WORD_WIDTH=4, FLUSH_CYCLES=16).
// A vector table covers back-to-back packing; hand-written sequences cover
// idle flush, output stall, flush coinciding with input, and async reset.
module tb_tag_stream_packer_wide;
  logic        clk;
  logic        rst;
  logic [31:0] stat_words;
  logic [31:0] stat_tags;
  int checks;
  int failures;

  tag_stream_packer_wide_if #(.WORD_WIDTH(4)) bus();

  tag_stream_packer_wide #(
    .WORD_WIDTH  (4),
    .FLUSH_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stat_words(stat_words),
    .stat_tags (stat_tags)
  );

  typedef struct {
    logic        valid;
    logic [63:0] t;
    logic        mready;
    logic        exp_sready;
    logic        exp_mvalid;
    logic [3:0]  exp_keep;
    logic [63:0] exp_base;
  } vec_t;

  vec_t vecs [11];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls the sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before test end");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of input; channel and edge are derived from the tag time
  task automatic applyStimulus(input logic valid, input logic [63:0] t, input logic mready);
    bus.s_axis_tvalid      = valid;
    bus.s_axis_tagtime     = t;
    bus.s_axis_channel     = t[4:0];
    bus.s_axis_rising_edge = t[0];
    bus.m_axis_tready      = mready;
    #1;
  endtask

  // Single comparison with failure report
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the whole output word against tags base, base+1, ... in kept lanes
  task automatic checkWord(input string name, input logic [3:0] keep, input logic [63:0] base);
    logic [63:0] e;
    checkOutput({name, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd1);
    checkOutput({name, "_tkeep"}, 64'(bus.m_axis_tkeep), 64'(keep));
    for (int i = 0; i < 4; i++) begin
      e = keep[i] ? base + 64'(i) : 64'd0;
      checkOutput($sformatf("%s_time%0d", name, i), bus.m_axis_tagtime[i], e);
      checkOutput($sformatf("%s_chan%0d", name, i), 64'(bus.m_axis_channel[i]), 64'(e[4:0]));
      checkOutput($sformatf("%s_edge%0d", name, i), 64'(bus.m_axis_rising_edge[i]), 64'(e[0]));
    end
  endtask

  // Step until a word appears (bounded); n counts edges since the reference accept
  task automatic waitForWord(input int already, input int expected, input string name);
    int n;
    n = already;
    while (!bus.m_axis_tvalid && n < 60) begin
      step();
      n++;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(expected));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 64'd100, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[1]  = '{1'b1, 64'd101, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[2]  = '{1'b1, 64'd102, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[3]  = '{1'b1, 64'd103, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[4]  = '{1'b1, 64'd104, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[5]  = '{1'b1, 64'd105, 1'b1, 1'b1, 1'b1, 4'hF, 64'd100};
    vecs[6]  = '{1'b1, 64'd106, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[7]  = '{1'b1, 64'd107, 1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[8]  = '{1'b0, 64'd0,   1'b1, 1'b1, 1'b0, 4'h0, 64'd0};
    vecs[9]  = '{1'b0, 64'd0,   1'b1, 1'b1, 1'b1, 4'hF, 64'd104};
    vecs[10] = '{1'b0, 64'd0,   1'b1, 1'b1, 1'b0, 4'h0, 64'd0};

    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput("rst_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
    checkOutput("rst_lane0", bus.m_axis_tagtime[0], 64'd0);
    checkOutput("rst_s_tready", 64'(bus.s_axis_tready), 64'd1);
    checkOutput("rst_stat_words", 64'(stat_words), 64'd0);
    step();

    $display("[TB] back-to-back packing table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].t, vecs[i].mready);
      checkOutput($sformatf("vec%0d_s_tready", i), 64'(bus.s_axis_tready), 64'(vecs[i].exp_sready));
      checkOutput($sformatf("vec%0d_m_tvalid", i), 64'(bus.m_axis_tvalid), 64'(vecs[i].exp_mvalid));
      if (vecs[i].exp_mvalid) begin
        checkWord($sformatf("vec%0d", i), vecs[i].exp_keep, vecs[i].exp_base);
      end
      step();
    end

    $display("[TB] idle flush of partial word");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 64'd200 + 64'(k), 1'b1);
      step();
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    waitForWord(0, 17, "flush");
    checkWord("flush", 4'h7, 64'd200);
    step();
`ifdef TAG_PACKER_STATS_EN
    checkOutput("stat_words_s12", 64'(stat_words), 64'd3);
    checkOutput("stat_tags_s12", 64'(stat_tags), 64'd11);
`else
    checkOutput("stat_words_off", 64'(stat_words), 64'd0);
    checkOutput("stat_tags_off", 64'(stat_tags), 64'd0);
`endif

    $display("[TB] output stall backpressure");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 64'd300 + 64'(k), 1'b0);
      checkOutput($sformatf("stall_s_tready%0d", k), 64'(bus.s_axis_tready), (k < 8) ? 64'd1 : 64'd0);
      if (k < 8) step();
    end
    for (int r = 0; r < 3; r++) begin
      checkWord($sformatf("stall_hold%0d", r), 4'hF, 64'd300);
      step();
      checkOutput($sformatf("stall_blocked%0d", r), 64'(bus.s_axis_tready), 64'd0);
    end
    applyStimulus(1'b1, 64'd308, 1'b1);
    checkOutput("release_s_tready", 64'(bus.s_axis_tready), 64'd1);
    step();
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkWord("release_w2", 4'hF, 64'd304);
    step();
    waitForWord(1, 17, "release_tail");
    checkWord("release_tail", 4'h1, 64'd308);
    step();

    $display("[TB] flush coinciding with new tag");
    applyStimulus(1'b1, 64'd400, 1'b1);
    step();
    applyStimulus(1'b1, 64'd401, 1'b1);
    step();
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (16) step();
    checkOutput("coinc_no_early", 64'(bus.m_axis_tvalid), 64'd0);
    applyStimulus(1'b1, 64'd402, 1'b1);
    checkOutput("coinc_s_tready", 64'(bus.s_axis_tready), 64'd1);
    step();
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkWord("coinc_old", 4'h3, 64'd400);
    step();
    waitForWord(1, 17, "coinc_new");
    checkWord("coinc_new", 4'h1, 64'd402);
    step();

    $display("[TB] async reset with partial and stalled word");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 64'd500 + 64'(k), 1'b0);
      checkOutput($sformatf("pre_rst_s_tready%0d", k), 64'(bus.s_axis_tready), 64'd1);
      step();
    end
    applyStimulus(1'b0, 64'd0, 1'b0);
    checkOutput("pre_rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput("async_rst_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
    checkOutput("async_rst_lane0", bus.m_axis_tagtime[0], 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'd600 + 64'(k), 1'b1);
      step();
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    step();
    checkWord("post_rst", 4'hF, 64'd600);
    step();
`ifndef TAG_PACKER_STATS_EN
    checkOutput("stat_words_end", 64'(stat_words), 64'd0);
    checkOutput("stat_tags_end", 64'(stat_tags), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
